jk_bank_sched: RTL

Round-robin scheduler sharing one bank of JK flip-flop cells between several requesters. Each requester issues a single-bit command (hold, reset, set, toggle) against one cell. The scheduler arbitrates, drives that cell's j/k for exactly one clock edge, and returns a one-cycle acknowledge. It sits between control agents and the JK storage bank, and is the only writer of the bank.

---
 rtl/jk_pkg.sv | 16 +
 rtl/jk_cell.sv | 31 +++
 rtl/jk_bank_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank scheduler: op encoding and FSM states.
package jk_pkg;

    // Op encoding is the {j,k} pair applied to the target cell
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/jk_cell.sv
// One behavioural JK flip-flop with synchronous active-high clear.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    // JK next-state: hold / reset / set / toggle, clear has priority
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                OP_HOLD: r_q <= r_q;
                OP_RST:  r_q <= 1'b0;
                OP_SET:  r_q <= 1'b1;
                OP_TGL:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler owning a bank of JK cells. One command is serviced
// every three cycles: capture in IDLE, drive j/k in APPLY, acknowledge in ACK.
module jk_bank_sched
    import jk_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1
)
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [IDXW*NREQ-1:0]   req_idx,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        ack,
    output logic                   ack_err,
    output logic                   busy,
    output logic [NBITS-1:0]       q
);

    localparam int IDW = $clog2(NREQ);
    // One extra bit so NBITS itself is representable for the range check
    localparam logic [IDXW:0] NB_L = (IDXW+1)'(NBITS);

    // First active requester at or above p, wrapping modulo NREQ
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] sel;
        logic [IDW-1:0] cand;
        logic           found;
        sel   = '0;
        found = 1'b0;
        for (int s = 0; s < NREQ; s++) begin
            cand = IDW'((int'(p) + s) % NREQ);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [IDW-1:0]    r_id;
    logic [IDW-1:0]    w_pick;
    logic [1:0]        r_op;
    logic [IDXW-1:0]   r_idx;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   w_grant_nxt;
    logic [NREQ-1:0]   r_ack;
    logic [NREQ-1:0]   w_ack_nxt;
    logic              r_ack_err;
    logic              w_ack_err_nxt;
    logic              w_capture;
    logic              w_idx_ok;
    logic [NBITS-1:0]  w_j;
    logic [NBITS-1:0]  w_k;

    assign w_pick   = rr_pick(req, r_ptr);
    assign w_idx_ok = ({1'b0, r_idx} < NB_L);

    // Next-state, pointer, grant and acknowledge decisions
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_ack_nxt     = '0;
        w_ack_err_nxt = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_capture   = 1'b1;
                    w_grant_nxt = NREQ'(1) << w_pick;
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                // Cell updates on this edge, so the ack cycle already shows new q
                w_ack_nxt     = r_grant;
                w_ack_err_nxt = !w_idx_ok;
                w_state_nxt   = S_ACK;
            end
            S_ACK: begin
                // Serviced requester drops to lowest priority next round
                w_ptr_nxt   = (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state register; clear discards any in-flight command
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_ack     <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_ack     <= w_ack_nxt;
            r_ack_err <= w_ack_err_nxt;
        end
    end

    // Command payload capture; only consumed after a capture so left unreset
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_op  <= req_op[2*w_pick +: 2];
            r_idx <= req_idx[IDXW*w_pick +: IDXW];
            r_id  <= w_pick;
        end
    end

    // Steer the latched op onto the target cell only; out-of-range hits nothing
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == S_APPLY) begin
            for (int b = 0; b < NBITS; b++) begin
                if (r_idx == IDXW'(b)) begin
                    w_j[b] = r_op[1];
                    w_k[b] = r_op[0];
                end
            end
        end
    end

    for (genvar g = 0; g < NBITS; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .clr (clr),
            .j   (w_j[g]),
            .k   (w_k[g]),
            .q   (q[g])
        );
    end

    assign grant   = r_grant;
    assign ack     = r_ack;
    assign ack_err = r_ack_err;
    assign busy    = (r_state != S_IDLE);

endmodule
